fetch_ctrl: RTL

Instruction-fetch sequencer for the RV32I pipeline. Owns the PC and issues single-beat AXI4 reads on the instruction master port. It presents each fetched instruction to the IF/ID pipeline register as pc/inst/valid, and holds it while the hazard unit stalls. It also handles branch/jump redirects, including discarding responses that are already in flight.

---
 rtl/fetch_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: RV32I instruction-fetch sequencer.
// Owns the PC and issues single-beat AXI4 reads, one request at a time.
// Each fetched instruction is presented to IF/ID as pc/inst/valid and held
// while the hazard unit stalls. Branch/jump redirects discard any response
// that is already in flight.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   i_stall            IF/ID not consuming the presented instruction
//   i_redirect(_pc)    taken branch/jump and its target (low 2 bits ignored)
//   o_pc/o_inst        presented instruction and its PC (0 when not valid)
//   o_valid_inst       presented instruction valid this cycle
//   o_fetch_err        one-cycle pulse after a non-OKAY read response
//   AXI AR/R           single-beat read master (arlen=0, 4-byte, INCR)
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst,
  output logic        o_valid_inst,
  output logic        o_fetch_err,
  output logic [31:0] o_araddr,
  output logic        o_arvalid,
  input  logic        i_arready,
  output logic [7:0]  o_arlen,
  output logic [2:0]  o_arsize,
  output logic [1:0]  o_arburst,
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_rresp,
  input  logic        i_rvalid,
  output logic        o_rready
);

  typedef enum logic [1:0] {
    ST_RST,
    ST_ADDR,
    ST_DATA,
    ST_PRESENT
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] ar_addr_q;
  logic [31:0] inst_q;
  logic        drop_q;
  logic        fetch_err_q;
  logic [31:0] redirect_tgt;
  logic [31:0] pc_next_seq;

  // Targets are word aligned; masking keeps every input bit in use.
  assign redirect_tgt = i_redirect_pc & 32'hFFFF_FFFC;
  assign pc_next_seq  = pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RST;
      pc_q        <= RESET_PC;
      ar_addr_q   <= '0;
      inst_q      <= '0;
      drop_q      <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      fetch_err_q <= 1'b0;
      case (state_q)
        ST_RST: begin
          state_q   <= ST_ADDR;
          ar_addr_q <= pc_q;
        end

        // ar_addr_q is left alone here so the address stays stable until
        // the handshake; a redirect only marks the response for discard.
        ST_ADDR: begin
          if (i_redirect) begin
            pc_q   <= redirect_tgt;
            drop_q <= 1'b1;
          end
          if (i_arready) begin
            state_q <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (i_rvalid) begin
            fetch_err_q <= (i_rresp != 2'b00);
            // A redirect coinciding with the beat drops it directly, so
            // drop_q never needs to be set for a response already here.
            if (drop_q || i_redirect) begin
              drop_q    <= 1'b0;
              state_q   <= ST_ADDR;
              ar_addr_q <= i_redirect ? redirect_tgt : pc_q;
              if (i_redirect) begin
                pc_q <= redirect_tgt;
              end
            end else begin
              inst_q  <= (i_rresp == 2'b00) ? i_rdata : NOP_INST;
              state_q <= ST_PRESENT;
            end
          end else if (i_redirect) begin
            pc_q   <= redirect_tgt;
            drop_q <= 1'b1;
          end
        end

        ST_PRESENT: begin
          if (i_redirect) begin
            pc_q      <= redirect_tgt;
            ar_addr_q <= redirect_tgt;
            state_q   <= ST_ADDR;
          end else if (!i_stall) begin
            pc_q      <= pc_next_seq;
            ar_addr_q <= pc_next_seq;
            state_q   <= ST_ADDR;
          end
        end

        default: state_q <= ST_RST;
      endcase
    end
  end

  assign o_valid_inst = (state_q == ST_PRESENT) && !i_redirect;
  assign o_pc         = o_valid_inst ? pc_q   : '0;
  assign o_inst       = o_valid_inst ? inst_q : '0;
  assign o_fetch_err  = fetch_err_q;

  assign o_arvalid = (state_q == ST_ADDR);
  assign o_araddr  = ar_addr_q;
  assign o_arlen   = 8'd0;
  assign o_arsize  = 3'b010;
  assign o_arburst = 2'b01;
  assign o_rready  = (state_q == ST_DATA);

endmodule
